// File: rtl/spi_alu_pkg.sv
// Shared types and constants for the SPI-slave arithmetic unit.
package spi_alu_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_RECEIVE = 3'd1;
  localparam state_t ST_EXECUTE = 3'd2;
  localparam state_t ST_WAIT_TX = 3'd3;
  localparam state_t ST_SEND    = 3'd4;

  localparam int unsigned OP_ADD  = 0;
  localparam int unsigned OP_SUB  = 1;
  localparam int unsigned OP_AND  = 2;
  localparam int unsigned OP_OR   = 3;
  localparam int unsigned OP_XOR  = 4;
  localparam int unsigned OP_SLL  = 5;
  localparam int unsigned OP_SRL  = 6;
  localparam int unsigned OP_SRA  = 7;
  localparam int unsigned OP_SLT  = 8;
  localparam int unsigned OP_SLTU = 9;

  // Flag vector is {INV, C, N, Z}; it sits above the result in the TX word.
  localparam int unsigned FLAG_W   = 4;
  localparam int unsigned FLAG_Z   = 0;
  localparam int unsigned FLAG_N   = 1;
  localparam int unsigned FLAG_C   = 2;
  localparam int unsigned FLAG_INV = 3;

endpackage

// File: rtl/spi_alu_core.sv
// Combinational ALU: (opcode, a, b) -> (result, {INV, C, N, Z}).
module spi_alu_core
  import spi_alu_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned OPCODE_W = 4
) (
  input  logic [OPCODE_W-1:0] opcode_i,
  input  logic [DATA_W-1:0]   a_i,
  input  logic [DATA_W-1:0]   b_i,
  output logic [DATA_W-1:0]   result_c_o,
  output logic [FLAG_W-1:0]   flags_c_o
);

  localparam int unsigned SH_W = $clog2(DATA_W);

  logic [SH_W-1:0]   sh;
  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] result;
  logic              carry;
  logic              inv;

  assign sh = b_i[SH_W-1:0];

  always_comb begin
    result = '0;
    carry  = 1'b0;
    inv    = 1'b0;
    sum    = '0;
    case (opcode_i)
      OPCODE_W'(OP_ADD): begin
        sum    = {1'b0, a_i} + {1'b0, b_i};
        result = sum[DATA_W-1:0];
        carry  = sum[DATA_W];
      end
      // Subtract as a + ~b + 1 so carry-out reads as "no borrow".
      OPCODE_W'(OP_SUB): begin
        sum    = {1'b0, a_i} + {1'b0, ~b_i} + (DATA_W+1)'(1);
        result = sum[DATA_W-1:0];
        carry  = sum[DATA_W];
      end
      OPCODE_W'(OP_AND):  result = a_i & b_i;
      OPCODE_W'(OP_OR):   result = a_i | b_i;
      OPCODE_W'(OP_XOR):  result = a_i ^ b_i;
      OPCODE_W'(OP_SLL):  result = a_i << sh;
      OPCODE_W'(OP_SRL):  result = a_i >> sh;
      OPCODE_W'(OP_SRA):  result = DATA_W'($signed(a_i) >>> sh);
      OPCODE_W'(OP_SLT):  result = DATA_W'($signed(a_i) < $signed(b_i));
      OPCODE_W'(OP_SLTU): result = DATA_W'(a_i < b_i);
      default:            inv    = 1'b1;
    endcase
  end

  always_comb begin
    flags_c_o           = '0;
    flags_c_o[FLAG_Z]   = (result == '0);
    flags_c_o[FLAG_N]   = result[DATA_W-1];
    flags_c_o[FLAG_C]   = carry;
    flags_c_o[FLAG_INV] = inv;
  end

  assign result_c_o = result;

endmodule

// File: rtl/spi_alu_slave.sv
// SPI mode-0 slave: receives {opcode, a, b}, executes once, returns {flags, result}.
module spi_alu_slave
  import spi_alu_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned OPCODE_W    = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic nss,
  input  logic sclk,
  input  logic mosi,
  output logic miso,
  output logic result_valid,
  output logic frame_err
);

  localparam int unsigned RX_LEN = OPCODE_W + 2 * DATA_W;
  localparam int unsigned TX_LEN = DATA_W + FLAG_W;
  localparam int unsigned CNT_W  = $clog2(RX_LEN + 1);

  logic [SYNC_STAGES-1:0] nss_sync_q, sclk_sync_q, mosi_sync_q;
  logic                   nss_prev_q, sclk_prev_q;
  logic                   nss_s, sclk_s, mosi_s;
  logic                   nss_fall_c, nss_rise_c, sclk_rise_c, sclk_fall_c;

  // nss history resets low so a frame already in progress at reset release
  // produces no fall; the slave waits for the master to deselect first.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      nss_sync_q  <= '0;
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      nss_prev_q  <= 1'b0;
      sclk_prev_q <= 1'b0;
    end else begin
      nss_sync_q  <= SYNC_STAGES'({nss_sync_q, nss});
      sclk_sync_q <= SYNC_STAGES'({sclk_sync_q, sclk});
      mosi_sync_q <= SYNC_STAGES'({mosi_sync_q, mosi});
      nss_prev_q  <= nss_s;
      sclk_prev_q <= sclk_s;
    end
  end

  assign nss_s       = nss_sync_q[SYNC_STAGES-1];
  assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
  assign nss_fall_c  = nss_prev_q & ~nss_s;
  assign nss_rise_c  = ~nss_prev_q & nss_s;
  assign sclk_rise_c = ~sclk_prev_q & sclk_s;
  assign sclk_fall_c = sclk_prev_q & ~sclk_s;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [RX_LEN-1:0]   rx_q, rx_d;
  logic [TX_LEN-1:0]   tx_q, tx_d;
  logic                miso_q, miso_d;
  logic                valid_q, valid_d;
  logic                ferr_q, ferr_d;
  logic [DATA_W-1:0]   alu_result;
  logic [FLAG_W-1:0]   alu_flags;

  spi_alu_core #(
    .DATA_W   (DATA_W),
    .OPCODE_W (OPCODE_W)
  ) u_core (
    .opcode_i   (rx_q[RX_LEN-1 -: OPCODE_W]),
    .a_i        (rx_q[2*DATA_W-1 -: DATA_W]),
    .b_i        (rx_q[DATA_W-1:0]),
    .result_c_o (alu_result),
    .flags_c_o  (alu_flags)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rx_q    <= '0;
      tx_q    <= '0;
      miso_q  <= 1'b0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rx_q    <= rx_d;
      tx_q    <= tx_d;
      miso_q  <= miso_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  // nss rise is tested before sclk edges so it wins a same-cycle collision.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rx_d    = rx_q;
    tx_d    = tx_q;
    miso_d  = miso_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (nss_fall_c) begin
          state_d = ST_RECEIVE;
          cnt_d   = '0;
        end
      end
      ST_RECEIVE: begin
        if (nss_rise_c) begin
          if (cnt_q == CNT_W'(RX_LEN)) begin
            state_d = ST_EXECUTE;
          end else begin
            ferr_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end else if (sclk_rise_c && (cnt_q < CNT_W'(RX_LEN))) begin
          rx_d  = {rx_q[RX_LEN-2:0], mosi_s};
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_EXECUTE: begin
        tx_d    = {alu_flags, alu_result};
        valid_d = 1'b1;
        state_d = ST_WAIT_TX;
      end
      ST_WAIT_TX: begin
        if (nss_fall_c) begin
          state_d = ST_SEND;
          cnt_d   = '0;
          miso_d  = tx_q[TX_LEN-1];
          tx_d    = {tx_q[TX_LEN-2:0], 1'b0};
        end
      end
      ST_SEND: begin
        if (nss_rise_c) begin
          ferr_d  = (cnt_q != CNT_W'(TX_LEN));
          state_d = ST_IDLE;
          valid_d = 1'b0;
          miso_d  = 1'b0;
          tx_d    = '0;
        end else begin
          if (sclk_rise_c && (cnt_q < CNT_W'(TX_LEN))) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          // Zeros shift in behind the word, so miso idles low once it is sent.
          if (sclk_fall_c) begin
            miso_d = tx_q[TX_LEN-1];
            tx_d   = {tx_q[TX_LEN-2:0], 1'b0};
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        miso_d  = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  assign miso         = miso_q;
  assign result_valid = valid_q;
  assign frame_err    = ferr_q;

endmodule

// File: tb/tb_spi_alu_slave.sv
// Scoreboard bench for spi_alu_slave: directed plan cases plus random commands.
module tb_spi_alu_slave;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned OPCODE_W = 4;
  localparam int unsigned RX_LEN   = OPCODE_W + 2 * DATA_W;
  localparam int unsigned TX_LEN   = DATA_W + 4;
  localparam int unsigned HALF     = 4;

  logic clock, reset, nss, sclk, mosi;
  logic miso, result_valid, frame_err;

  int total = 0;
  int bad   = 0;
  int ferr_cnt = 0;
  logic rd_active = 1'b0;
  int rd_bits = 0;
  logic [TX_LEN-1:0] rd_word = '0;
  logic [TX_LEN-1:0] exp_q[$];

  spi_alu_slave #(
    .DATA_W      (DATA_W),
    .OPCODE_W    (OPCODE_W),
    .SYNC_STAGES (2)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .nss          (nss),
    .sclk         (sclk),
    .mosi         (mosi),
    .miso         (miso),
    .result_valid (result_valid),
    .frame_err    (frame_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) if (frame_err === 1'b1) ferr_cnt <= ferr_cnt + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: TX word {INV, C, N, Z, result} from plain arithmetic.
  function automatic logic [TX_LEN-1:0] model(input int op, input logic [31:0] a,
                                               input logic [31:0] b);
    logic [31:0] r;
    logic [63:0] s;
    logic c, inv;
    int sh;
    r = '0; c = 1'b0; inv = 1'b0; sh = int'(b % 32);
    case (op)
      0: begin s = {32'd0, a} + {32'd0, b}; r = s[31:0]; c = s[32]; end
      1: begin r = a - b; c = (a >= b); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = a << sh;
      6: r = a >> sh;
      7: r = $signed(a) >>> sh;
      8: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      9: r = (a < b) ? 32'd1 : 32'd0;
      default: inv = 1'b1;
    endcase
    return {inv, c, r[31], (r == 32'd0), r};
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic bit_cycle(input logic b);
    mosi = b;
    wait_clk(HALF);
    sclk = 1'b1;
    wait_clk(HALF);
    sclk = 1'b0;
  endtask

  task automatic spi_cmd(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int nbits);
    logic [RX_LEN-1:0] w;
    w = {op, a, b};
    if (nbits >= RX_LEN) exp_q.push_back(model(int'(op), a, b));
    nss = 1'b0;
    wait_clk(HALF);
    for (int i = 0; i < nbits; i++) bit_cycle((i < RX_LEN) ? w[RX_LEN-1-i] : 1'($urandom));
    wait_clk(HALF);
    nss = 1'b1;
    wait_clk(3 * HALF);
  endtask

  task automatic spi_read(input int nbits);
    rd_active = 1'b1;
    nss = 1'b0;
    wait_clk(HALF);
    for (int i = 0; i < nbits; i++) bit_cycle(1'($urandom));
    wait_clk(HALF);
    nss = 1'b1;
    wait_clk(1);
    rd_active = 1'b0;
    wait_clk(3 * HALF);
  endtask

  task automatic txn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                     input int extra);
    spi_cmd(op, a, b, RX_LEN + extra);
    chk("valid_held", 64'(result_valid), 64'd1);
    spi_read(TX_LEN + extra);
    chk("valid_clr", 64'(result_valid), 64'd0);
  endtask

  // Monitor: samples miso on sclk rise; a completed read frame is scored
  // against the oldest expectation, a truncated one discards it.
  initial begin
    logic [TX_LEN-1:0] e;
    forever begin
      @(posedge sclk or posedge nss);
      if (nss === 1'b1) begin
        if (rd_active) begin
          if (rd_bits >= TX_LEN) begin
            if (exp_q.size() == 0) begin
              chk("unexpected_read", 64'(rd_word), 64'hDEAD_BEEF_DEAD);
            end else begin
              e = exp_q.pop_front();
              chk("tx_word", 64'(rd_word), 64'(e));
            end
          end else if (exp_q.size() != 0) begin
            void'(exp_q.pop_front());
          end
        end
        rd_bits = 0;
      end else if (nss === 1'b0) begin
        if (rd_active) begin
          if (rd_bits < TX_LEN) rd_word = {rd_word[TX_LEN-2:0], miso};
          rd_bits++;
        end else begin
          chk("miso_quiet", 64'(miso), 64'd0);
        end
      end
    end
  end

  initial begin
    int ferr_before;
    reset = 1'b0; nss = 1'b1; sclk = 1'b0; mosi = 1'b0;
    wait_clk(5);
    chk("rst_miso", 64'(miso), 64'd0);
    chk("rst_valid", 64'(result_valid), 64'd0);
    chk("rst_ferr", 64'(frame_err), 64'd0);
    reset = 1'b1;
    wait_clk(10);

    txn(4'd0, 32'hFFFF_FFFF, 32'h0000_0001, 0);
    txn(4'd1, 32'd5, 32'd7, 0);
    txn(4'd1, 32'd7, 32'd5, 0);
    txn(4'd7, 32'h8000_0000, 32'd4, 0);
    txn(4'd6, 32'h8000_0000, 32'd4, 0);
    txn(4'd8, 32'hFFFF_FFFF, 32'd1, 0);
    txn(4'd9, 32'hFFFF_FFFF, 32'd1, 0);
    txn(4'hF, 32'h1234_5678, 32'h9ABC_DEF0, 0);

    // Short command frame.
    ferr_before = ferr_cnt;
    spi_cmd(4'd0, 32'd1, 32'd1, 20);
    chk("short_ferr", 64'(ferr_cnt - ferr_before), 64'd1);
    chk("short_miso", 64'(miso), 64'd0);
    chk("short_valid", 64'(result_valid), 64'd0);
    txn(4'd0, 32'd3, 32'd4, 0);

    // Reset during readout.
    spi_cmd(4'd0, 32'd1, 32'd2, RX_LEN);
    rd_active = 1'b1;
    nss = 1'b0;
    wait_clk(HALF);
    for (int i = 0; i < 10; i++) bit_cycle(1'($urandom));
    reset = 1'b0;
    wait_clk(2);
    chk("rstmid_miso", 64'(miso), 64'd0);
    chk("rstmid_valid", 64'(result_valid), 64'd0);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bit_cycle(1'($urandom));
      chk("rstmid_ignore", 64'(miso), 64'd0);
    end
    wait_clk(HALF);
    nss = 1'b1;
    wait_clk(1);
    rd_active = 1'b0;
    wait_clk(3 * HALF);
    chk("rstmid_valid2", 64'(result_valid), 64'd0);
    txn(4'd4, 32'hAAAA_5555, 32'hFFFF_0000, 0);

    // Random commands, some with surplus clocks after the frame.
    ferr_before = ferr_cnt;
    for (int n = 0; n < 40; n++) begin
      logic [3:0] op;
      logic [31:0] a, b;
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      txn(op, a, b, int'($urandom_range(0, 2)));
    end
    chk("rand_no_ferr", 64'(ferr_cnt - ferr_before), 64'd0);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
